// File: rtl/memory_access.sv
// memory_access: fourth pipeline stage. Resolves branches, runs byte/half/word
// loads and stores over a req/ack data port with an IDLE/WAIT FSM, and
// registers result/rd/write_reg for write-back and forwarding.
// Ports: clk, rst (sync, active-low); *_from_execution stage inputs;
// dmem_* data-memory port; branch_*/stall_from_memory combinational outputs;
// result/rd/write_reg/misaligned_from_memory registered outputs.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them.
module memory_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] branch_addr_from_execution,
   input  logic [31:0] result_from_execution,
   input  logic [31:0] rs2_data_from_execution,
   input  logic        equal_from_execution,
   input  logic        greater_from_execution,
   input  logic        lesser_from_execution,
   input  logic [2:0]  funct3_from_execution,
   input  logic [4:0]  rd_from_execution,
   input  logic        write_reg_from_execution,
   input  logic        select_from_execution,
   input  logic        read_from_execution,
   input  logic        write_from_execution,
   input  logic        branch_from_execution,
   input  logic        u_branch_from_execution,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   output logic        branch_taken_from_memory,
   output logic [31:0] branch_addr_from_memory,
   output logic        stall_from_memory,
   output logic [31:0] result_from_memory,
   output logic [4:0]  rd_from_memory,
   output logic        write_reg_from_memory,
   output logic        misaligned_from_memory
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_q, rd_d;
   logic        write_reg_q, write_reg_d;

   logic        access;
   logic        is_half;
   logic        is_word;
   logic        trap;
   logic        go;
   logic [1:0]  lo;
   logic [2:0]  f3;
   logic [31:0] a;
   logic [31:0] rs2;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] load_val;
   logic        cond;
   logic        unused_greater;

   assign f3      = funct3_from_execution;
   assign a       = result_from_execution;
   assign rs2     = rs2_data_from_execution;
   assign access  = read_from_execution | write_from_execution;
   assign is_half = (f3[1:0] == 2'b01);
   assign is_word = (f3[1:0] == 2'b10);

   // The signed comparison is fully covered by equal/lesser.
   assign unused_greater = greater_from_execution;

`ifdef MISALIGN_TRAP_EN
   logic mis_q, mis_d;

   assign trap = access
               & ((is_half & a[0]) | (is_word & (|a[1:0])));
   assign lo   = a[1:0];
`else
   assign trap = 1'b0;
   // Misaligned offsets are rounded down to the access size.
   assign lo   = is_word ? 2'b00
               : is_half ? {a[1], 1'b0}
               : a[1:0];
`endif

   assign go = access & ~trap;

   // FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (go & ~dmem_ack) state_d = S_WAIT;
         S_WAIT: if (dmem_ack)       state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   assign dmem_req = rst
                   & (((state_q == S_IDLE) & go)
                     | (state_q == S_WAIT));
   assign dmem_we  = write_from_execution;
   assign dmem_addr = {a[31:2], 2'b00};
   assign stall_from_memory = dmem_req & ~dmem_ack;

   // Store lanes
   always_comb begin
      dmem_be    = 4'b0000;
      dmem_wdata = rs2;
      unique case (f3[1:0])
         2'b00: begin
            dmem_be    = 4'b0001 << lo;
            dmem_wdata = {4{rs2[7:0]}};
         end
         2'b01: begin
            dmem_be    = 4'b0011 << lo;
            dmem_wdata = {2{rs2[15:0]}};
         end
         2'b10: dmem_be = 4'b1111;
         default: dmem_be = 4'b0000;
      endcase
      if (!write_from_execution) dmem_be = 4'b0000;
   end

   // Load lane select and extension
   assign ld_b = dmem_rdata[{lo, 3'b000} +: 8];
   assign ld_h = lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      load_val = dmem_rdata;
      unique case (f3)
         3'b000: load_val = {{24{ld_b[7]}}, ld_b};
         3'b001: load_val = {{16{ld_h[15]}}, ld_h};
         3'b100: load_val = {24'd0, ld_b};
         3'b101: load_val = {16'd0, ld_h};
         default: load_val = dmem_rdata;
      endcase
   end

   // Branch resolution
   always_comb begin
      cond = 1'b0;
      unique case (f3)
         3'b000:         cond = equal_from_execution;
         3'b001:         cond = ~equal_from_execution;
         3'b100, 3'b110: cond = lesser_from_execution;
         3'b101, 3'b111: cond = ~lesser_from_execution;
         default:        cond = 1'b0;
      endcase
   end

   assign branch_taken_from_memory = u_branch_from_execution
                                   | (branch_from_execution & cond);
   assign branch_addr_from_memory  = branch_addr_from_execution;

   // Output registers hold while stalled
   always_comb begin
      result_d    = result_q;
      rd_d        = rd_q;
      write_reg_d = write_reg_q;
      if (!stall_from_memory) begin
         result_d    = (select_from_execution & read_from_execution)
                     ? load_val : result_from_execution;
         rd_d        = rd_from_execution;
         write_reg_d = write_reg_from_execution & ~trap;
      end
   end

`ifdef MISALIGN_TRAP_EN
   assign mis_d = trap & ~stall_from_memory;
   assign misaligned_from_memory = mis_q;

   always_ff @(posedge clk) begin
      if (!rst) mis_q <= 1'b0;
      else      mis_q <= mis_d;
   end
`else
   assign misaligned_from_memory = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         result_q    <= 32'd0;
         rd_q        <= 5'd0;
         write_reg_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         rd_q        <= rd_d;
         write_reg_q <= write_reg_d;
      end
   end

   assign result_from_memory    = result_q;
   assign rd_from_memory        = rd_q;
   assign write_reg_from_memory = write_reg_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized scoreboard bench for memory_access.
// Byte-array reference model; separate word-array memory slave.
module tb_memory_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] br_addr, res_ex, rs2_ex;
   logic        eq, gt, lt;
   logic [2:0]  f3_ex;
   logic [4:0]  rd_ex;
   logic        wreg_ex, sel_ex, rd_en, wr_en, br_ex, ub_ex;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        taken;
   logic [31:0] taken_addr;
   logic        stall;
   logic [31:0] res_mem;
   logic [4:0]  rd_mem;
   logic        wreg_mem, mis_mem;

   always #5 clk = ~clk;

   memory_access dut (
      .clk                        (clk),
      .rst                        (rst),
      .branch_addr_from_execution (br_addr),
      .result_from_execution      (res_ex),
      .rs2_data_from_execution    (rs2_ex),
      .equal_from_execution       (eq),
      .greater_from_execution     (gt),
      .lesser_from_execution      (lt),
      .funct3_from_execution      (f3_ex),
      .rd_from_execution          (rd_ex),
      .write_reg_from_execution   (wreg_ex),
      .select_from_execution      (sel_ex),
      .read_from_execution        (rd_en),
      .write_from_execution       (wr_en),
      .branch_from_execution      (br_ex),
      .u_branch_from_execution    (ub_ex),
      .dmem_rdata                 (dmem_rdata),
      .dmem_ack                   (dmem_ack),
      .dmem_req                   (dmem_req),
      .dmem_we                    (dmem_we),
      .dmem_addr                  (dmem_addr),
      .dmem_wdata                 (dmem_wdata),
      .dmem_be                    (dmem_be),
      .branch_taken_from_memory   (taken),
      .branch_addr_from_memory    (taken_addr),
      .stall_from_memory          (stall),
      .result_from_memory         (res_mem),
      .rd_from_memory             (rd_mem),
      .write_reg_from_memory      (wreg_mem),
      .misaligned_from_memory     (mis_mem)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        wr;
      logic        mis;
      logic        chk_res;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] slave_mem [16];
   logic [7:0]  ref_mem [64];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic ref_taken(input logic br, ub,
                                      input logic e, l,
                                      input logic [2:0] f);
      logic c;
      case (f)
         3'd0:       c = e;
         3'd1:       c = !e;
         3'd4, 3'd6: c = l;
         3'd5, 3'd7: c = !l;
         default:    c = 1'b0;
      endcase
      return ub | (br & c);
   endfunction

   task automatic set_word(input int idx, input logic [31:0] w);
      slave_mem[idx] = w;
      for (int j = 0; j < 4; j++) ref_mem[4*idx+j] = w[8*j +: 8];
   endtask

   task automatic issue(input logic r, w, s, wr, b, u,
                        input logic [2:0] f,
                        input logic [31:0] a, d, ba,
                        input logic [4:0] rd,
                        input logic e, l, g,
                        input int lat);
      int          n;
      int          ea;
      logic        trap;
      logic [31:0] lv;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      exp_t        x;
      rd_en = r; wr_en = w; sel_ex = s; wreg_ex = wr;
      br_ex = b; ub_ex = u; f3_ex = f; res_ex = a;
      rs2_ex = d; br_addr = ba; rd_ex = rd;
      eq = e; lt = l; gt = g;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = (r | w) && ((int'(a[5:0]) % n) != 0);
`endif
      ea = int'(a[5:0]) - (int'(a[5:0]) % n);
      lv = 32'd0;
      if (r && !trap) begin
         for (int i = 0; i < n; i++) lv[8*i +: 8] = ref_mem[ea+i];
         if (!f[2] && n < 4 && lv[8*n-1])
            lv = lv | (32'hFFFF_FFFF << (8*n));
      end
      ebe = 4'b0000;
      ewd = d;
      if (w && !trap) begin
         for (int i = 0; i < n; i++) begin
            ebe[(ea % 4) + i] = 1'b1;
            ref_mem[ea+i] = d[8*i +: 8];
         end
         if (n == 1) ewd = {4{d[7:0]}};
         if (n == 2) ewd = {2{d[15:0]}};
      end
      x.res = (s & r) ? lv : a;
      x.rd = rd;
      x.wr = wr & !trap;
      x.mis = trap;
      x.chk_res = !trap;
      sb.push_back(x);
      #1;
      chk("br_taken", taken, ref_taken(b, u, e, l, f));
      chk("br_addr", taken_addr, ba);
      if ((r | w) && !trap) begin
         for (int c = 0; c <= lat; c++) begin
            chk("req", dmem_req, 1);
            chk("we", dmem_we, w);
            chk("addr", dmem_addr, {a[31:2], 2'b00});
            chk("be", dmem_be, ebe);
            if (w) chk("wdata", dmem_wdata, ewd);
            if (c == lat) begin
               dmem_ack = 1'b1;
               dmem_rdata = slave_mem[a[5:2]];
               if (w)
                  for (int j = 0; j < 4; j++)
                     if (dmem_be[j])
                        slave_mem[a[5:2]][8*j +: 8] =
                           dmem_wdata[8*j +: 8];
               #1;
               chk("stall_ack", stall, 0);
            end else begin
               chk("stall_wait", stall, 1);
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (c < lat) #1;
         end
      end else begin
         chk("req_none", dmem_req, 0);
         chk("stall_none", stall, 0);
         // stray ack with no request must be ignored
         dmem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         dmem_ack = 1'b0;
      end
   endtask

   task automatic reset_mid_wait();
      rd_en = 1; wr_en = 0; sel_ex = 1; wreg_ex = 1;
      br_ex = 0; ub_ex = 0; f3_ex = 3'b010;
      res_ex = 32'h104; rd_ex = 5'd9; dmem_ack = 0;
      #1;
      chk("rw_req", dmem_req, 1);
      @(negedge clk);
      #1;
      chk("rw_stall", stall, 1);
      rst = 1'b0;
      #1;
      chk("rw_req_rst", dmem_req, 0);
      @(negedge clk);
      #1;
      chk("rw_res", res_mem, 0);
      chk("rw_rd", rd_mem, 0);
      chk("rw_wreg", wreg_mem, 0);
      chk("rw_mis", mis_mem, 0);
      rst = 1'b1;
   endtask

   initial begin : mon
      logic commit;
      exp_t e;
      forever begin
         @(posedge clk);
         commit = rst && !stall;
         #1;
         if (commit) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               if (e.chk_res) chk("result", res_mem, e.res);
               chk("rd", rd_mem, e.rd);
               chk("wreg", wreg_mem, e.wr);
               chk("mis", mis_mem, e.mis);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : drv
      logic [2:0] ldf [5];
      int         k;
      int         cmp;
      logic       r, w;
      ldf[0] = 3'b000; ldf[1] = 3'b001; ldf[2] = 3'b010;
      ldf[3] = 3'b100; ldf[4] = 3'b101;
      rst = 0; br_addr = 0; res_ex = 0; rs2_ex = 0;
      eq = 0; gt = 0; lt = 0; f3_ex = 0; rd_ex = 0;
      wreg_ex = 0; sel_ex = 0; rd_en = 0; wr_en = 0;
      br_ex = 0; ub_ex = 0; dmem_rdata = 0; dmem_ack = 0;
      for (int i = 0; i < 16; i++) set_word(i, $urandom);
      set_word(0, 32'h80FF_FF00);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_res", res_mem, 0);
      chk("rst_rd", rd_mem, 0);
      chk("rst_wreg", wreg_mem, 0);
      chk("rst_mis", mis_mem, 0);
      @(negedge clk);
      rst = 1'b1;
      // ALU pass-through
      issue(0,0,0,1,0,0,3'b000,32'h1234,0,0,5'd5,0,0,0,0);
      // LB 0x103, ack after 3 extra cycles
      issue(1,0,1,1,0,0,3'b000,32'h103,0,0,5'd7,0,0,0,3);
      // SH 0x102, same-cycle ack
      issue(0,1,0,0,0,0,3'b001,32'h102,32'hABCD_1234,0,
            5'd0,0,0,0,0);
      // BGE not-lesser, BNE equal, JAL
      issue(0,0,0,0,1,0,3'b101,32'h0,0,32'hDEAD_BEE0,
            5'd0,0,0,1,0);
      issue(0,0,0,0,1,0,3'b001,32'h0,0,32'h0000_4000,
            5'd0,1,0,0,0);
      issue(0,0,0,1,0,1,3'b000,32'h8,0,32'h0000_0800,
            5'd1,0,1,0,0);
      // LW misaligned
      issue(1,0,1,1,0,0,3'b010,32'h102,0,0,5'd3,0,0,0,1);
      reset_mid_wait();
      issue(0,0,0,1,0,0,3'b011,32'h55,0,0,5'd4,0,0,0,0);
      for (int t = 0; t < 300; t++) begin
         k = $urandom_range(0, 2);
         cmp = $urandom_range(0, 2);
         r = (k == 1);
         w = (k == 2);
         issue(r, w,
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               (k == 0) && ($urandom_range(0, 2) == 0),
               (k == 0) && ($urandom_range(0, 5) == 0),
               r ? ldf[$urandom_range(0, 4)]
                 : w ? 3'($urandom_range(0, 2))
                     : 3'($urandom_range(0, 7)),
               (k == 0) ? $urandom
                        : (32'h100 | $urandom_range(0, 63)),
               $urandom, $urandom,
               5'($urandom_range(0, 31)),
               cmp == 0, cmp == 1, cmp == 2,
               $urandom_range(0, 3));
      end
      rst = 1'b0;
      #1;
      chk("end_req", dmem_req, 0);
      @(negedge clk);
      #1;
      chk("end_res", res_mem, 0);
      chk("end_wreg", wreg_mem, 0);
      chk("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
